// File: rtl/lpm_memory_server_if.sv
// Handshake bundle for lpm_memory_server: request, response, table-config and rule ports.
// The design takes the slave modport; the driving side takes master.
interface lpm_memory_server_if #(
   parameter int DATA_WIDTH = 704
);
   logic                  req__ENA;
   logic [DATA_WIDTH-1:0] req_v;
   logic                  req__RDY;
   logic [DATA_WIDTH-1:0] resValue;
   logic                  resValue__RDY;
   logic                  resAccept__ENA;
   logic                  resAccept__RDY;
   logic                  cfg__ENA;
   logic [3:0]            cfg_addr;
   logic [31:0]           cfg_data;
   logic                  cfg__RDY;
   logic                  rule_enable;
   logic                  rule_ready;

   modport slave (
      input  req__ENA, req_v, resAccept__ENA, cfg__ENA, cfg_addr, cfg_data, rule_enable,
      output req__RDY, resValue, resValue__RDY, resAccept__RDY, cfg__RDY, rule_ready
   );

   modport master (
      output req__ENA, req_v, resAccept__ENA, cfg__ENA, cfg_addr, cfg_data, rule_enable,
      input  req__RDY, resValue, resValue__RDY, resAccept__RDY, cfg__RDY, rule_ready
   );
endinterface

// File: rtl/lpm_memory_server.sv
// In-order request server: each request captures a table lookup, then waits DELAY memdelay
// firings before it is presented; req__RDY drops when all DEPTH slots are held (no pop bypass).
module lpm_memory_server #(
   parameter int DATA_WIDTH = 704,
   parameter int DELAY      = 4,
   parameter int DEPTH      = 2
) (
   input logic                CLK,
   input logic                nRST,
   lpm_memory_server_if.slave bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   logic [31:0]           table_q [16];
   logic [31:0]           table_d [16];
   logic [DATA_WIDTH-1:0] pay_q   [DEPTH];
   logic [DATA_WIDTH-1:0] pay_d   [DEPTH];
   logic [3:0]            down_q  [DEPTH];
   logic [3:0]            down_d  [DEPTH];
   ptr_t                  head_q, head_d, tail_q, tail_d;
   cnt_t                  count_q, count_d;

   logic [DEPTH-1:0] occ;
   logic             memdelay_rdy, res_rdy, req_rdy, enq, deq, fire;
   logic             unused_idx_bits;

   assign unused_idx_bits = ^bus.req_v[31:4];

   // A slot is live when its distance from head is below the occupancy count.
   always_comb begin
      occ          = '0;
      memdelay_rdy = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         occ[i] = cnt_t'(ptr_t'(ptr_t'(i) - head_q)) < count_q;
         if (occ[i] && down_q[i] != 4'd0) memdelay_rdy = 1'b1;
      end
   end

   assign res_rdy = nRST && (count_q != '0) && (down_q[head_q] == 4'd0);
   assign req_rdy = (count_q < cnt_t'(DEPTH));
   assign enq     = nRST && bus.req__ENA && req_rdy;
   assign deq     = nRST && bus.resAccept__ENA && res_rdy;
   assign fire    = bus.rule_enable && memdelay_rdy;

   always_comb begin
      table_d = table_q;
      pay_d   = pay_q;
      down_d  = down_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (bus.cfg__ENA) table_d[bus.cfg_addr] = bus.cfg_data;
      for (int i = 0; i < DEPTH; i++) begin
         if (fire && occ[i] && down_q[i] != 4'd0) down_d[i] = down_q[i] - 4'd1;
      end
      // The tail slot is never live while enqueueing, so this cannot collide with a decrement.
      if (enq) begin
         pay_d[tail_q]  = {bus.req_v[DATA_WIDTH-1:32], table_q[bus.req_v[3:0]]};
         down_d[tail_q] = 4'(DELAY);
         tail_d         = ptr_t'(tail_q + 1'b1);
      end
      if (deq) head_d = ptr_t'(head_q + 1'b1);
      case ({enq, deq})
         2'b10:   count_d = count_q + cnt_t'(1);
         2'b01:   count_d = count_q - cnt_t'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         for (int i = 0; i < 16; i++) table_q[i] <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pay_q[i]  <= '0;
            down_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         table_q <= table_d;
         pay_q   <= pay_d;
         down_q  <= down_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign bus.req__RDY       = !nRST || req_rdy;
   assign bus.resValue__RDY  = res_rdy;
   assign bus.resAccept__RDY = res_rdy;
   assign bus.resValue       = res_rdy ? pay_q[head_q] : '0;
   assign bus.cfg__RDY       = nRST;
   assign bus.rule_ready     = nRST && memdelay_rdy;
endmodule

// File: tb/tb_lpm_memory_server.sv
// Directed bench for lpm_memory_server; stimulus pushes expected responses, an
// independent monitor pops them as the design presents and accepts each response.
module tb_lpm_memory_server;
   localparam int DW    = 704;
   localparam int DELAY = 4;
   localparam int DEPTH = 2;
   typedef logic [DW-1:0] pl_t;

   logic CLK = 1'b0;
   logic nRST;
   always #5 CLK = ~CLK;

   lpm_memory_server_if #(.DATA_WIDTH(DW)) bus();

   lpm_memory_server #(.DATA_WIDTH(DW), .DELAY(DELAY), .DEPTH(DEPTH)) dut (
      .CLK (CLK),
      .nRST(nRST),
      .bus (bus)
   );

   int    checks   = 0;
   int    failures = 0;
   pl_t   exp_q[$];
   bit    accept_en  = 1'b0;
   bit    stall_rand = 1'b0;
   logic [31:0] model_tbl [16];

   task automatic check(input string name, input pl_t act, input pl_t req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input pl_t v, input pl_t e);
      int n = 0;
      while (bus.req__RDY !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) begin
         check("send_timeout", pl_t'(bus.req__RDY), pl_t'(1));
         return;
      end
      bus.req__ENA = 1'b1;
      bus.req_v    = v;
      tick();
      bus.req__ENA = 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
      bus.cfg__ENA  = 1'b1;
      bus.cfg_addr  = a;
      bus.cfg_data  = d;
      tick();
      bus.cfg__ENA  = 1'b0;
      model_tbl[a]  = d;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check("drain", pl_t'(exp_q.size()), pl_t'(0));
   endtask

   // Response monitor: owns resAccept__ENA and compares every popped response in order.
   initial begin
      bus.resAccept__ENA = 1'b0;
      forever begin
         @(negedge CLK);
         bus.resAccept__ENA = 1'b0;
         if (nRST === 1'b1 && bus.resValue__RDY === 1'b1 && accept_en &&
             (!stall_rand || $urandom_range(0, 2) != 0)) begin
            if (exp_q.size() == 0) begin
               check("unexpected_response", pl_t'(bus.resValue__RDY), pl_t'(0));
            end else begin
               check("order_payload", bus.resValue, exp_q[0]);
               bus.resAccept__ENA = 1'b1;
               #1;
               check("no_full_bypass", pl_t'(bus.req__RDY), pl_t'(exp_q.size() < DEPTH));
               void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      pl_t v, e;
      bus.req__ENA    = 1'b0;
      bus.req_v       = '0;
      bus.cfg__ENA    = 1'b0;
      bus.cfg_addr    = '0;
      bus.cfg_data    = '0;
      bus.rule_enable = 1'b0;
      for (int i = 0; i < 16; i++) model_tbl[i] = '0;

      // Reset state, both during and after reset.
      nRST = 1'b0;
      tick();
      tick();
      check("rst_cfg_rdy",     pl_t'(bus.cfg__RDY),      pl_t'(0));
      check("rst_req_rdy",     pl_t'(bus.req__RDY),      pl_t'(1));
      check("rst_res_rdy",     pl_t'(bus.resValue__RDY), pl_t'(0));
      check("rst_acc_rdy",     pl_t'(bus.resAccept__RDY),pl_t'(0));
      check("rst_res_value",   bus.resValue,             pl_t'(0));
      check("rst_rule_ready",  pl_t'(bus.rule_ready),    pl_t'(0));
      nRST = 1'b1;
      #1;
      check("post_rst_cfg_rdy", pl_t'(bus.cfg__RDY), pl_t'(1));
      check("post_rst_req_rdy", pl_t'(bus.req__RDY), pl_t'(1));
      bus.rule_enable = 1'b1;

      // Table lookup and exact DELAY latency.
      cfg_write(4'd3, 32'hDEADBEEF);
      for (int b = 0; b < DW / 8; b++) v[8*b +: 8] = 8'hA5;
      v[3:0] = 4'd3;
      e = v;
      e[31:0] = 32'hDEADBEEF;
      accept_en = 1'b1;
      send(v, e);
      check("lat_cycle0", pl_t'(bus.resValue__RDY), pl_t'(0));
      check("rule_ready_busy", pl_t'(bus.rule_ready), pl_t'(1));
      for (int k = 1; k <= DELAY; k++) begin
         tick();
         check($sformatf("lat_cycle%0d", k), pl_t'(bus.resValue__RDY), pl_t'(k == DELAY));
      end
      check("lat_value", bus.resValue, e);
      wait_drain(20);

      // Full FIFO: back-to-back fill, held-off third request, RDY back one cycle after a pop.
      accept_en = 1'b0;
      send({672'h1, 32'h0000_0000}, {672'h1, 32'h0000_0000});
      send({672'h2, 32'h0000_0003}, {672'h2, 32'hDEADBEEF});
      check("full_req_rdy", pl_t'(bus.req__RDY), pl_t'(0));
      bus.req__ENA = 1'b1;
      bus.req_v    = {672'hBAD, 32'h0000_0003};
      tick();
      bus.req__ENA = 1'b0;
      check("full_held_off", pl_t'(bus.req__RDY), pl_t'(0));
      for (int k = 0; k < 3; k++) tick();
      check("full_head_value", bus.resValue, {672'h1, 32'h0000_0000});
      accept_en = 1'b1;
      tick();
      check("rdy_after_pop", pl_t'(bus.req__RDY), pl_t'(1));
      wait_drain(20);
      for (int k = 0; k < DELAY + 2; k++) tick();
      check("held_off_not_enqueued", pl_t'(bus.resValue__RDY), pl_t'(0));

      // memdelay disabled holds countdowns.
      bus.rule_enable = 1'b0;
      send({672'h3, 32'h0000_0003}, {672'h3, 32'hDEADBEEF});
      for (int k = 0; k < 10; k++) begin
         tick();
         check("disabled_no_ready", pl_t'(bus.resValue__RDY), pl_t'(0));
      end
      check("disabled_rule_ready", pl_t'(bus.rule_ready), pl_t'(1));
      bus.rule_enable = 1'b1;
      for (int k = 1; k <= DELAY; k++) begin
         tick();
         check($sformatf("reenable_cycle%0d", k), pl_t'(bus.resValue__RDY), pl_t'(k == DELAY));
      end
      wait_drain(20);

      // Same-cycle table write and request to the same index sees the old entry.
      bus.cfg__ENA = 1'b1;
      bus.cfg_addr = 4'd5;
      bus.cfg_data = 32'h0000_0001;
      send({672'h5, 32'h0000_0005}, {672'h5, 32'h0000_0000});
      bus.cfg__ENA = 1'b0;
      model_tbl[5] = 32'h0000_0001;
      send({672'h6, 32'h0000_0005}, {672'h6, 32'h0000_0001});
      wait_drain(30);

      // Reset mid-operation drops outstanding requests and clears the table.
      accept_en = 1'b0;
      send({672'h7, 32'h0}, {672'h7, 32'h0});
      send({672'h8, 32'h0}, {672'h8, 32'h0});
      check("pre_rst_full", pl_t'(bus.req__RDY), pl_t'(0));
      nRST = 1'b0;
      #1;
      check("mid_rst_req_rdy", pl_t'(bus.req__RDY),      pl_t'(1));
      check("mid_rst_res_rdy", pl_t'(bus.resValue__RDY), pl_t'(0));
      check("mid_rst_cfg_rdy", pl_t'(bus.cfg__RDY),      pl_t'(0));
      tick();
      nRST = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 16; i++) model_tbl[i] = '0;
      #1;
      check("after_rst_req_rdy",    pl_t'(bus.req__RDY),  pl_t'(1));
      check("after_rst_rule_ready", pl_t'(bus.rule_ready), pl_t'(0));
      accept_en = 1'b1;
      for (int k = 0; k < DELAY + 3; k++) begin
         tick();
         check("dropped_no_response", pl_t'(bus.resValue__RDY), pl_t'(0));
      end

      // Streaming with random accept stalls; odd entries stay at their cleared value.
      for (int i = 0; i < 16; i += 2) cfg_write(4'(i), 32'hC0DE_0000 | 32'(i));
      stall_rand = 1'b1;
      for (int n = 0; n < 20; n++) begin
         for (int w = 1; w < DW / 32; w++) v[32*w +: 32] = $urandom;
         v[31:0] = 32'(n % 16);
         e = {v[DW-1:32], model_tbl[n % 16]};
         send(v, e);
      end
      wait_drain(500);
      stall_rand = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/lpm_memory_server.md
LPM_MEMORY_SERVER -- requirements
Module: lpm_memory_server

Interface
REQ-001 Parameter DATA_WIDTH, default 704, width of request/response payload (minimum 36).
REQ-002 Parameter DELAY, default 4, memdelay rule firings from enqueue to response-ready (1..15).
REQ-003 Parameter DEPTH, default 2, outstanding-request slots (power of 2, 2..8).
REQ-004 CLK  in  1  sole clock, all state on rising edge.
REQ-005 nRST  in  1  synchronous, active-low reset.
REQ-006 req__ENA  in  1  enqueue request; asserted only while req__RDY=1.
REQ-007 req_v  in  DATA_WIDTH  request payload; index = req_v[3:0].
REQ-008 req__RDY  out  1  slot available.
REQ-009 resValue  out  DATA_WIDTH  head response payload.
REQ-010 resValue__RDY  out  1  head response ready.
REQ-011 resAccept__ENA  in  1  pop head; asserted only while resAccept__RDY=1.
REQ-012 resAccept__RDY  out  1  equals resValue__RDY.
REQ-013 cfg__ENA / cfg_addr[3:0] / cfg_data[31:0]  in  table write port.
REQ-014 cfg__RDY  out  1  tied to 1 outside reset.
REQ-015 rule_enable  in  1  bit 0 enables the memdelay rule.
REQ-016 rule_ready  out  1  bit 0 = memdelay__RDY.

Function
REQ-017 Block SHALL hold a 16x32 lookup table, written at cfg__ENA: table[cfg_addr] <= cfg_data.
REQ-018 Accepted request SHALL capture payload {req_v[DATA_WIDTH-1:32], table[req_v[3:0]]} and countdown = DELAY into the tail slot.
REQ-019 Same-cycle cfg write and request to the same index: request SHALL capture the old table value.
REQ-020 Slots SHALL form a circular FIFO; head/tail pointers wrap modulo DEPTH; count 0..DEPTH.
REQ-021 req__RDY SHALL be (count < DEPTH); no full-bypass: when full, a same-cycle resAccept does not make req__RDY=1 in that cycle.
REQ-022 memdelay__RDY SHALL be 1 when any occupied slot has countdown > 0.
REQ-023 When rule_enable[0] && memdelay__RDY, every occupied slot with countdown > 0 SHALL decrement by 1; a slot enqueued in the same cycle is not decremented.
REQ-024 resValue__RDY SHALL be 1 when count > 0 and head countdown == 0; resValue = head payload, else resValue = 0.
REQ-025 Responses SHALL leave strictly in request order; a younger ready slot never bypasses an older one.
REQ-026 resAccept__ENA SHALL free head slot and advance head at the clock edge.
REQ-027 Simultaneous req and resAccept (count between 1 and DEPTH-1) SHALL leave count unchanged.
REQ-028 Minimum latency: request accepted edge t, memdelay enabled every cycle → resValue__RDY=1 in cycle t+DELAY.
REQ-029 memdelay disabled → countdowns SHALL hold; no response becomes ready.
REQ-030 ENA asserted while corresponding RDY=0 SHALL be ignored (no state change).

Reset
REQ-031 nRST=0 at a rising edge SHALL clear count, pointers, countdowns, and all table entries to 0.
REQ-032 During and after reset: req__RDY=1, resValue__RDY=0, resAccept__RDY=0, resValue=0, rule_ready[0]=0; cfg__RDY=0 while nRST=0.
REQ-033 Reset mid-operation SHALL drop all outstanding requests; no response is produced for them.

Verification
REQ-034 cfg write table[3]=0xDEADBEEF; req_v low nibble 3, upper bits 0xA5 pattern; memdelay on → resValue=upper 0xA5 bits, low word 0xDEADBEEF, ready exactly 4 cycles after request.
REQ-035 DEPTH=2: enqueue 2 requests back-to-back → req__RDY=0; third request held off; after one resAccept, req__RDY=1 next cycle.
REQ-036 rule_enable[0]=0 for 10 cycles after request → resValue__RDY stays 0; re-enable → ready 4 enabled cycles later.
REQ-037 Same-cycle cfg write table[5]=0x1 (old 0x0) and request index 5 → response low word 0x0.
REQ-038 Fill both slots, assert nRST=0 for one cycle → count 0, resValue__RDY=0, req__RDY=1, table[*]=0.
REQ-039 Stream 20 requests, indices 0..15 wrapping, random resAccept stalls → responses in order with correct table values, pointer wrap verified.
